ds1302_time_poller: RTL
=======================

# ds1302_time_poller

Command sequencer directly upstream of the DS1302 driver stack. Issues a periodic one-hot command sequence (read seconds, minutes, hours) to the DS1302 command controller, handshakes on its completion pulse, and presents a coherent BCD time snapshot to the display/application logic. Optionally performs a power-on set-time sequence before polling begins.

## Interface
- POLL_CYCLES, 5_000_000: CLK cycles between poll sequences (100 ms at 50 MHz); must be ≥ 2.
- TIMEOUT_CYCLES, 1_000_000: max cycles a command may stay outstanding before abort.
- INIT_SEC, 8'h00: BCD seconds written at init (CH bit forced 0).
- INIT_MIN, 8'h00: BCD minutes written at init.
- INIT_HOUR, 8'h12: BCD hours written at init (24 h mode, bit7 forced 0).

- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset; synchronous and active-high.
- Start_Sig  out  8  one-hot command to DS1302 command controller: [7] write-protect off, [6] write hour, [5] write minute, [4] write second, [2] read hour, [1] read minute, [0] read second; [3] is always 0.
- Done_Sig  in  1  one-cycle completion pulse from the command controller.
- Time_Write_Data  out  8  data for write commands; 8'h00 otherwise.
- Time_Read_Data  in  8  read result, valid in the cycle Done_Sig is high.
- Sec_Bcd  out  8  seconds, bit7 (CH) masked to 0.
- Min_Bcd  out  8  minutes, bit7 masked to 0.
- Hour_Bcd  out  8  hours, bits 7:6 masked to 0.
- Time_Valid  out  1  one-cycle pulse when a new snapshot is committed.
- Time_Err  out  1  sticky timeout flag.

## Operation
- States: WP_OFF, W_SEC, W_MIN, W_HOUR (init only), WAIT, RD_SEC, RD_MIN, RD_HOUR, COMMIT.
- Each command state has two phases: ISSUE (Start_Sig = its one-hot bit, held) and GAP (Start_Sig = 0 for exactly one cycle), then advances.
- Reads captured into shadow registers on Done_Sig; Sec/Min/Hour_Bcd update only in COMMIT, all three on the same edge (no torn snapshot).
- Order: [init: WP_OFF → W_SEC → W_MIN → W_HOUR →] RD_SEC → RD_MIN → RD_HOUR → COMMIT → WAIT → RD_SEC…
- WAIT counts POLL_CYCLES−1 down to 0, then enters RD_SEC.
- Timeout: outstanding counter reaches TIMEOUT_CYCLES → drop Start_Sig, set Time_Err, discard shadows, go to WAIT (full reload). Init-phase timeout also goes to WAIT; init is not retried.
- Time_Err cleared in COMMIT of the next fully successful sequence, or by RST.
- Done_Sig outside an ISSUE phase is ignored.

## Timing
- Reset values: Start_Sig 0, Time_Write_Data 0, Sec_Bcd/Min_Bcd 0, Hour_Bcd 0, Time_Valid 0, Time_Err 0.
- First command: Start_Sig asserted the cycle after RST deasserts (WP_OFF with init, RD_SEC without).
- Start_Sig and Time_Write_Data change only on entry to ISSUE; stable until Done_Sig sampled high.
- Done_Sig sampled at cycle n → Start_Sig 0 at n+1 (GAP) → next command's Start_Sig at n+2.
- Done_Sig coincident with the timeout-count terminal cycle: Done wins, no error.
- RD_HOUR Done at n → COMMIT at n+2 (after GAP); outputs and Time_Valid update at that edge, Time_Valid low at n+3.
- RST mid-command: all outputs return to reset values on that edge; sequence restarts from the top.

## Configuration
- DS1302_TIME_INIT_EN defined: after reset run WP_OFF (data 8'h00), W_SEC (INIT_SEC & 8'h7F), W_MIN (INIT_MIN), W_HOUR (INIT_HOUR & 8'h7F), then polling.
- Undefined: init states and INIT_* logic absent; reset goes straight to RD_SEC; Time_Write_Data tied to 8'h00; Start_Sig[7:4] tied 0.

## Structure
- Shared ds1302_pkg: Start_Sig bit indices/one-hot constants, state encoding, BCD field masks (8'h7F, 8'h3F).
- One sub-module: ds1302_cmd_issuer — ISSUE/GAP handshake plus timeout counter; reports done/timeout to the sequencer FSM.

## Test plan
- No init, model returns 8'h59/8'h59/8'h23 after 10 cycles each → Start_Sig 01,02,04 in order with 1-cycle gaps; Sec/Min/Hour_Bcd = 59/59/23 and Time_Valid single pulse, all in one cycle.
- Read seconds returns 8'hD5 (CH set) → Sec_Bcd = 8'h55; hour returns 8'hE3 → Hour_Bcd = 8'h23.
- POLL_CYCLES=20 → consecutive RD_SEC Start_Sig rises exactly 20 cycles after COMMIT apart; outputs unchanged between.
- Model never answers RD_MIN, TIMEOUT_CYCLES=50 → Start_Sig drops after 50 cycles, Time_Err=1, no Time_Valid; next good sequence clears Time_Err at COMMIT.
- DS1302_TIME_INIT_EN, INIT 30/45/08 → Start_Sig 80,10,20,40 with Time_Write_Data 00,30,45,08, then reads begin.
- RST asserted while RD_MIN outstanding → Start_Sig 0 next edge; after release RD_SEC restarts; spurious Done_Sig in WAIT ignored.

Source files
------------

// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 time poller: Start_Sig bit map, one-hot
// commands, sequencer/issuer state encodings and BCD field masks.
package ds1302_pkg;

  localparam int BIT_R_SEC  = 0;
  localparam int BIT_R_MIN  = 1;
  localparam int BIT_R_HOUR = 2;
  localparam int BIT_W_SEC  = 4;
  localparam int BIT_W_MIN  = 5;
  localparam int BIT_W_HOUR = 6;
  localparam int BIT_WP_OFF = 7;

  localparam logic [7:0] CMD_NONE   = 8'h00;
  localparam logic [7:0] CMD_R_SEC  = 8'(1) << BIT_R_SEC;
  localparam logic [7:0] CMD_R_MIN  = 8'(1) << BIT_R_MIN;
  localparam logic [7:0] CMD_R_HOUR = 8'(1) << BIT_R_HOUR;
  localparam logic [7:0] CMD_W_SEC  = 8'(1) << BIT_W_SEC;
  localparam logic [7:0] CMD_W_MIN  = 8'(1) << BIT_W_MIN;
  localparam logic [7:0] CMD_W_HOUR = 8'(1) << BIT_W_HOUR;
  localparam logic [7:0] CMD_WP_OFF = 8'(1) << BIT_WP_OFF;
  localparam logic [7:0] READ_CMD_MASK = CMD_R_SEC | CMD_R_MIN | CMD_R_HOUR;

  localparam logic [7:0] MASK_SEC_MIN = 8'h7F;
  localparam logic [7:0] MASK_HOUR    = 8'h3F;
  localparam logic [7:0] MASK_24H     = 8'h7F;

  typedef enum logic [3:0] {
    ST_WP_OFF, ST_W_SEC, ST_W_MIN, ST_W_HOUR, ST_WAIT,
    ST_RD_SEC, ST_RD_MIN, ST_RD_HOUR, ST_COMMIT
  } state_t;

  typedef enum logic [1:0] {PH_IDLE, PH_ISSUE, PH_GAP} phase_t;

  function automatic logic [7:0] state_cmd(input state_t s);
    case (s)
      ST_WP_OFF:  return CMD_WP_OFF;
      ST_W_SEC:   return CMD_W_SEC;
      ST_W_MIN:   return CMD_W_MIN;
      ST_W_HOUR:  return CMD_W_HOUR;
      ST_RD_SEC:  return CMD_R_SEC;
      ST_RD_MIN:  return CMD_R_MIN;
      ST_RD_HOUR: return CMD_R_HOUR;
      default:    return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ds1302_cmd_issuer.sv
// ISSUE/GAP handshake toward the DS1302 command controller with an
// outstanding-command timeout; reports completion and abort to the sequencer.
module ds1302_cmd_issuer
  import ds1302_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] cmd,
  input  logic [7:0] wdata,
  input  logic       done_in,
  output logic [7:0] start,
  output logic [7:0] wr_data,
  output logic       cmd_done,
  output logic       cmd_timeout,
  output logic       ready
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  phase_t      phase;
  logic [31:0] out_cnt;

  // Done on the terminal count cycle wins over the timeout.
  assign cmd_done    = (phase == PH_ISSUE) && done_in;
  assign cmd_timeout = (phase == PH_ISSUE) && !done_in && (out_cnt == TO_LAST);
  assign ready       = (phase != PH_ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= PH_IDLE;
      start   <= CMD_NONE;
      wr_data <= 8'h00;
      out_cnt <= '0;
    end else begin
      case (phase)
        PH_IDLE, PH_GAP: begin
          if (go) begin
            phase   <= PH_ISSUE;
            start   <= cmd;
            wr_data <= wdata;
            out_cnt <= '0;
          end else begin
            phase <= PH_IDLE;
          end
        end
        PH_ISSUE: begin
          if (cmd_done) begin
            phase   <= PH_GAP;
            start   <= CMD_NONE;
            wr_data <= 8'h00;
          end else if (cmd_timeout) begin
            phase   <= PH_IDLE;
            start   <= CMD_NONE;
            wr_data <= 8'h00;
          end else begin
            out_cnt <= out_cnt + 32'd1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ds1302_time_poller.sv
// Periodic seconds/minutes/hours poller for the DS1302 command controller with
// a torn-free BCD snapshot. Define DS1302_TIME_INIT_EN for the power-on set-time run.
module ds1302_time_poller
  import ds1302_pkg::*;
#(
  parameter int unsigned POLL_CYCLES    = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  INIT_SEC       = 8'h00,
  parameter logic [7:0]  INIT_MIN       = 8'h00,
  parameter logic [7:0]  INIT_HOUR      = 8'h12
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [7:0] Start_Sig,
  input  logic       Done_Sig,
  output logic [7:0] Time_Write_Data,
  input  logic [7:0] Time_Read_Data,
  output logic [7:0] Sec_Bcd,
  output logic [7:0] Min_Bcd,
  output logic [7:0] Hour_Bcd,
  output logic       Time_Valid,
  output logic       Time_Err
);

  localparam logic [31:0] WAIT_LOAD = 32'(POLL_CYCLES - 1);
`ifdef DS1302_TIME_INIT_EN
  localparam state_t FIRST_STATE = ST_WP_OFF;
`else
  localparam state_t FIRST_STATE = ST_RD_SEC;
`endif

  state_t      state, issue_state;
  logic [31:0] wait_cnt;
  logic [7:0]  issue_cmd, issue_wdata;
  logic        iss_go, iss_done, iss_timeout, iss_ready;
  logic [7:0]  sh_sec, sh_min, sh_hour;

  // The last WAIT cycle launches RD_SEC directly so the period is exact.
  always_comb begin
    issue_state = ((state == ST_WAIT) && (wait_cnt == '0)) ? ST_RD_SEC : state;
    issue_wdata = 8'h00;
`ifdef DS1302_TIME_INIT_EN
    issue_cmd = state_cmd(issue_state);
    case (issue_state)
      ST_W_SEC:  issue_wdata = INIT_SEC & MASK_SEC_MIN;
      ST_W_MIN:  issue_wdata = INIT_MIN;
      ST_W_HOUR: issue_wdata = INIT_HOUR & MASK_24H;
      default:   issue_wdata = 8'h00;
    endcase
`else
    issue_cmd = state_cmd(issue_state) & READ_CMD_MASK;
`endif
    iss_go = iss_ready && (issue_cmd != CMD_NONE);
  end

  ds1302_cmd_issuer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_issuer (
    .clk        (CLK),
    .rst        (RST),
    .go         (iss_go),
    .cmd        (issue_cmd),
    .wdata      (issue_wdata),
    .done_in    (Done_Sig),
    .start      (Start_Sig),
    .wr_data    (Time_Write_Data),
    .cmd_done   (iss_done),
    .cmd_timeout(iss_timeout),
    .ready      (iss_ready)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= FIRST_STATE;
      wait_cnt   <= '0;
      Sec_Bcd    <= 8'h00;
      Min_Bcd    <= 8'h00;
      Hour_Bcd   <= 8'h00;
      Time_Valid <= 1'b0;
      Time_Err   <= 1'b0;
    end else begin
      Time_Valid <= 1'b0;
      if (iss_timeout) begin
        Time_Err <= 1'b1;
        state    <= ST_WAIT;
        wait_cnt <= WAIT_LOAD;
      end else begin
        case (state)
`ifdef DS1302_TIME_INIT_EN
          ST_WP_OFF: if (iss_done) state <= ST_W_SEC;
          ST_W_SEC:  if (iss_done) state <= ST_W_MIN;
          ST_W_MIN:  if (iss_done) state <= ST_W_HOUR;
          ST_W_HOUR: if (iss_done) state <= ST_RD_SEC;
`endif
          ST_RD_SEC:  if (iss_done) state <= ST_RD_MIN;
          ST_RD_MIN:  if (iss_done) state <= ST_RD_HOUR;
          ST_RD_HOUR: if (iss_done) state <= ST_COMMIT;
          ST_COMMIT: begin
            Sec_Bcd    <= sh_sec & MASK_SEC_MIN;
            Min_Bcd    <= sh_min & MASK_SEC_MIN;
            Hour_Bcd   <= sh_hour & MASK_HOUR;
            Time_Valid <= 1'b1;
            Time_Err   <= 1'b0;
            state      <= ST_WAIT;
            wait_cnt   <= WAIT_LOAD;
          end
          ST_WAIT: begin
            if (wait_cnt == '0) state <= ST_RD_SEC;
            else                wait_cnt <= wait_cnt - 32'd1;
          end
          default: state <= FIRST_STATE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (iss_timeout) begin
      sh_sec  <= 8'h00;
      sh_min  <= 8'h00;
      sh_hour <= 8'h00;
    end else if (iss_done) begin
      case (state)
        ST_RD_SEC:  sh_sec  <= Time_Read_Data;
        ST_RD_MIN:  sh_min  <= Time_Read_Data;
        ST_RD_HOUR: sh_hour <= Time_Read_Data;
        default: ;
      endcase
    end
  end

endmodule
